vga_sprite_ctrl: RTL and testbench
==================================

Name: vga_sprite_ctrl

Overview:
Parametrised VGA timing generator plus single-sprite renderer, the next generation of the fixed 640x480 sprite display. Timing, sprite size, colour depth and pixel divider are parameters. Sprite position is a runtime input, latched once per frame. Sits between the sprite ROM/RAM (one row per read) and the board DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width
V_BP, 33, vertical back porch
SPR_W, 64, sprite width in pixels; readata width
SPR_H, 48, sprite height in rows; readaddress range 0..SPR_H-1
COLOR_W, 4, bits per colour channel
PIX_DIV, 2, clk cycles per pixel (>=1)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
sprite_x  in  10  sprite left column, sampled at frame start
sprite_y  in  10  sprite top line, sampled at frame start
rgb  in  3  sprite colour enable: bit0 red, bit1 green, bit2 blue
readaddress  out  $clog2(SPR_H)  sprite row address
readata  in  SPR_W  sprite row bitmap; bit i = column i, LSB leftmost
hsync  out  1  active-low horizontal sync
vsync  out  1  active-low vertical sync
red/green/blue  out  COLOR_W each  pixel colour
active  out  1  high while the output pixel is in the visible area
frame_start  out  1  one-clk pulse at h=0,v=0 pixel tick

Behaviour:
- Reset is asynchronous and active-high, on clk. All outputs reset: hsync=1, vsync=1, colours=0, active=0, frame_start=0, readaddress=0. Counters and divider reset to 0.
- pix_en is high one clk in every PIX_DIV. With PIX_DIV=1, pix_en is constantly 1.
- h_cnt counts 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters, and advances on pix_en. v_cnt counts 0..V_TOTAL-1 and advances when h_cnt wraps. No off-by-one: defaults give exactly 800x525.
- hsync is low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync is low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
- All video outputs are registered and updated on pix_en. Latency is 1 pixel tick from counter to pins. Sync, active and colour stay mutually aligned.
- sprite_x and sprite_y are latched into pos_x/pos_y on the tick where h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1. Changes mid-frame have no effect until the next frame, so there is no tearing.
- Row fetch:
  - readaddress is registered and updated on the last tick of each line (h_cnt=H_TOTAL-1) to next_v - pos_y, where next_v is the upcoming line.
  - The value is held for the entire line. readata must be valid at least 1 clk after the address changes; it is then stable for the whole line.
  - Outside sprite rows, readaddress holds 0.
- Pixel is a sprite pixel when: h<H_ACTIVE, v<V_ACTIVE, pos_x<=h<pos_x+SPR_W, pos_y<=v<pos_y+SPR_H, and readata[h-pos_x]=1.
- A sprite pixel drives each channel to all-ones when its rgb bit is set, else 0. Every other pixel, including the entire blanking interval, is 0.
- Comparisons use 11-bit arithmetic, so pos+SPR_W beyond 1023 cannot wrap. A sprite partially off-screen is clipped. pos_x>=H_ACTIVE or pos_y>=V_ACTIVE draws nothing.
- Reset mid-frame: outputs return to reset values immediately, and the next frame starts at h=0,v=0 after release.

Optional Feature:
VGA_SPRITE_HFLIP_EN:
- Defined: adds input port hflip (1 bit), latched with the sprite position at frame start. When latched high, the column index is SPR_W-1-(h-pos_x).
- Undefined: no hflip port; column index is h-pos_x.

Decomposition:
- Package vga_pkg holds:
  - default timing localparams (640x480@60)
  - RGB bit index constants (RGB_R=0, RGB_G=1, RGB_B=2)
  - typedef vga_cnt_t (logic [10:0])
- Sub-module vga_timing holds the divider, h/v counters, raw sync and active signals, and the line-end/frame-end strobes. vga_sprite_ctrl instantiates it and adds position latching, row fetch and colour registers.

Test Plan:
- Reset, then run 2 frames with defaults: hsync low exactly 96 ticks per 800; vsync low exactly 2 lines per 525; frame_start period 840000 clk.
- sprite_x=250, sprite_y=250, readata=64'h1, rgb=3'b001: only column 250 of lines 250..297 has red=4'hF; readaddress steps 0..47; green=blue=0.
- Change sprite_x to 100 mid-frame (v=300): current frame is unchanged at x=250; the next frame draws at x=100.
- sprite_x=600, readata all-ones, rgb=3'b111: white from h=600..639 only; h=640..799 all black, active=0.
- Assert rst at v=200,h=400 for 3 clk: outputs are at reset values within the same clk edge; after release, frame_start pulses at the first pixel tick.
- With VGA_SPRITE_HFLIP_EN, hflip=1, readata=64'h1: lit pixel at column pos_x+63.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - default 640x480@60 timing, RGB bit indices and the shared counter type
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int SPR_W_DEF    = 64;
  localparam int SPR_H_DEF    = 48;
  localparam int COLOR_W_DEF  = 4;
  localparam int PIX_DIV_DEF  = 2;

  localparam int RGB_R = 0;
  localparam int RGB_G = 1;
  localparam int RGB_B = 2;

  // 11 bits so that position + sprite size never wraps
  typedef logic [10:0] vga_cnt_t;

endpackage

// File: rtl/vga_sprite_ctrl_if.sv
// rtl/vga_sprite_ctrl_if.sv - sprite position/memory and video pin bundle; hflip only with VGA_SPRITE_HFLIP_EN
interface vga_sprite_ctrl_if #(
  parameter int SPR_W   = 64,
  parameter int SPR_H   = 48,
  parameter int COLOR_W = 4
);
  localparam int AW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

  logic [9:0]         sprite_x;
  logic [9:0]         sprite_y;
  logic [2:0]         rgb;
`ifdef VGA_SPRITE_HFLIP_EN
  logic               hflip;
`endif
  logic [AW-1:0]      readaddress;
  logic [SPR_W-1:0]   readata;
  logic               hsync;
  logic               vsync;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic               active;
  logic               frame_start;

  modport master (
`ifdef VGA_SPRITE_HFLIP_EN
    input  hflip,
`endif
    input  sprite_x, sprite_y, rgb, readata,
    output readaddress, hsync, vsync, red, green, blue, active, frame_start
  );

  modport slave (
`ifdef VGA_SPRITE_HFLIP_EN
    output hflip,
`endif
    output sprite_x, sprite_y, rgb, readata,
    input  readaddress, hsync, vsync, red, green, blue, active, frame_start
  );

endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - pixel divider, h/v counters, raw sync/active and line/frame end strobes
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int PIX_DIV  = PIX_DIV_DEF
) (
  input  logic     clk,
  input  logic     rst,
  output logic     pix_en_o,
  output vga_cnt_t h_o,
  output vga_cnt_t v_o,
  output logic     hsync_o,
  output logic     vsync_o,
  output logic     active_o,
  output logic     line_end_o,
  output logic     frame_end_o
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  vga_cnt_t         h_q, h_d, v_q, v_d;

  // With PIX_DIV=1 the divider never leaves 0, so pix_en is constantly high
  assign pix_en_o    = (div_q == '0);
  assign line_end_o  = pix_en_o && (h_q == vga_cnt_t'(H_TOTAL - 1));
  assign frame_end_o = line_end_o && (v_q == vga_cnt_t'(V_TOTAL - 1));

  always_comb begin
    div_d = (div_q == DIV_W'(PIX_DIV - 1)) ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (pix_en_o) begin
      if (line_end_o) begin
        h_d = '0;
        v_d = frame_end_o ? '0 : v_q + 1'b1;
      end else begin
        h_d = h_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign h_o      = h_q;
  assign v_o      = v_q;
  assign hsync_o  = !((h_q >= vga_cnt_t'(H_ACTIVE + H_FP)) &&
                      (h_q <  vga_cnt_t'(H_ACTIVE + H_FP + H_SYNC)));
  assign vsync_o  = !((v_q >= vga_cnt_t'(V_ACTIVE + V_FP)) &&
                      (v_q <  vga_cnt_t'(V_ACTIVE + V_FP + V_SYNC)));
  assign active_o = (h_q < vga_cnt_t'(H_ACTIVE)) && (v_q < vga_cnt_t'(V_ACTIVE));

endmodule

// File: rtl/vga_sprite_ctrl.sv
// rtl/vga_sprite_ctrl.sv - VGA timing plus single-sprite renderer with per-frame position latch
// Optional horizontal mirroring when VGA_SPRITE_HFLIP_EN is defined.
module vga_sprite_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int SPR_W    = SPR_W_DEF,
  parameter int SPR_H    = SPR_H_DEF,
  parameter int COLOR_W  = COLOR_W_DEF,
  parameter int PIX_DIV  = PIX_DIV_DEF
) (
  input  logic              clk,
  input  logic              rst,
  vga_sprite_ctrl_if.master bus
);
  localparam int AW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int XW = (SPR_W > 1) ? $clog2(SPR_W) : 1;

  logic     pix_en, line_end, frame_end;
  logic     hsync_raw, vsync_raw, active_raw;
  vga_cnt_t h_cnt, v_cnt;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .PIX_DIV(PIX_DIV)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .pix_en_o    (pix_en),
    .h_o         (h_cnt),
    .v_o         (v_cnt),
    .hsync_o     (hsync_raw),
    .vsync_o     (vsync_raw),
    .active_o    (active_raw),
    .line_end_o  (line_end),
    .frame_end_o (frame_end)
  );

  vga_cnt_t           pos_x_q, pos_y_q, pos_y_n, next_v;
  logic [AW-1:0]      raddr_q, raddr_d;
  logic [XW-1:0]      col;
  logic               in_x, in_y, sprite_px;
  logic               hsync_q, vsync_q, active_q, frame_start_q;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;
`ifdef VGA_SPRITE_HFLIP_EN
  logic               hflip_q;
`endif

  // Address for the upcoming line; on the frame-end tick that line belongs to the new position
  always_comb begin
    next_v  = frame_end ? '0 : v_cnt + 11'd1;
    pos_y_n = frame_end ? {1'b0, bus.sprite_y} : pos_y_q;
    raddr_d = raddr_q;
    if (line_end) begin
      raddr_d = '0;
      if ((next_v < vga_cnt_t'(V_ACTIVE)) && (next_v >= pos_y_n) &&
          (next_v < pos_y_n + vga_cnt_t'(SPR_H)))
        raddr_d = AW'(next_v - pos_y_n);
    end
  end

  always_comb begin
    in_x = (h_cnt >= pos_x_q) && (h_cnt < pos_x_q + vga_cnt_t'(SPR_W));
    in_y = (v_cnt >= pos_y_q) && (v_cnt < pos_y_q + vga_cnt_t'(SPR_H));
`ifdef VGA_SPRITE_HFLIP_EN
    col  = hflip_q ? XW'(SPR_W - 1) - XW'(h_cnt - pos_x_q) : XW'(h_cnt - pos_x_q);
`else
    col  = XW'(h_cnt - pos_x_q);
`endif
    sprite_px = active_raw && in_x && in_y && bus.readata[col];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else if (frame_end) begin
      pos_x_q <= {1'b0, bus.sprite_x};
      pos_y_q <= pos_y_n;
    end
  end

`ifdef VGA_SPRITE_HFLIP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            hflip_q <= 1'b0;
    else if (frame_end) hflip_q <= bus.hflip;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      red_q         <= '0;
      green_q       <= '0;
      blue_q        <= '0;
      frame_start_q <= 1'b0;
      raddr_q       <= '0;
    end else begin
      raddr_q       <= raddr_d;
      frame_start_q <= pix_en && (h_cnt == '0) && (v_cnt == '0);
      if (pix_en) begin
        hsync_q  <= hsync_raw;
        vsync_q  <= vsync_raw;
        active_q <= active_raw;
        red_q    <= {COLOR_W{sprite_px & bus.rgb[RGB_R]}};
        green_q  <= {COLOR_W{sprite_px & bus.rgb[RGB_G]}};
        blue_q   <= {COLOR_W{sprite_px & bus.rgb[RGB_B]}};
      end
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.active      = active_q;
  assign bus.red         = red_q;
  assign bus.green       = green_q;
  assign bus.blue        = blue_q;
  assign bus.frame_start = frame_start_q;
  assign bus.readaddress = raddr_q;

endmodule

// File: tb/tb_vga_sprite_ctrl.sv
// tb/tb_vga_sprite_ctrl.sv - scoreboard bench for vga_sprite_ctrl on a reduced raster
module tb_vga_sprite_ctrl;
  import vga_pkg::*;

  localparam int HA = 32, HF = 4, HS = 6, HB = 4;
  localparam int VA = 24, VF = 2, VS = 2, VB = 3;
  localparam int SW = 16, SH = 8, CW = 4, PD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME_CLK = HT * VT * PD;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic [14:0] vec;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_sprite_ctrl_if #(.SPR_W(SW), .SPR_H(SH), .COLOR_W(CW)) bus ();

  vga_sprite_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SPR_W(SW), .SPR_H(SH), .COLOR_W(CW), .PIX_DIV(PD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [SW-1:0] mem [SH];
  assign bus.readata = mem[bus.readaddress];

  int total = 0;
  int bad   = 0;

  int   m_div, m_h, m_v, m_px, m_py, m_ra;
  logic m_flip;
  exp_t sb[$];

  int cyc, frames, fs_last_cyc;
  logic frame_valid;
  int acc_hs, acc_vs, acc_red, acc_gb, acc_white, acc_lit, acc_blank, acc_lit_h;
  int f_hs, f_vs, f_red, f_gb, f_white, f_lit, f_blank, f_lit_h;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_acc();
    acc_hs = 0; acc_vs = 0; acc_red = 0; acc_gb = 0;
    acc_white = 0; acc_lit = 0; acc_blank = 0; acc_lit_h = -1;
  endtask

  task automatic reset_model();
    m_div = 0; m_h = 0; m_v = 0; m_px = 0; m_py = 0; m_ra = 0; m_flip = 1'b0;
    sb.delete();
    frame_valid = 1'b0;
    fs_last_cyc = -1;
    clear_acc();
  endtask

  task automatic set_mem(input logic [SW-1:0] row);
    for (int r = 0; r < SH; r++) mem[r] = row;
  endtask

  task automatic tick();
    logic pix, exp_fs, spr, hs, vs, act;
    int row, col, nv, npy;
    exp_t e;
    logic [14:0] obs;
    pix    = (m_div == 0);
    exp_fs = pix && (m_h == 0) && (m_v == 0);
    if (pix) begin
      spr = 1'b0;
      hs  = !((m_h >= HA + HF) && (m_h < HA + HF + HS));
      vs  = !((m_v >= VA + VF) && (m_v < VA + VF + VS));
      act = (m_h < HA) && (m_v < VA);
      if (act && m_h >= m_px && m_h < m_px + SW && m_v >= m_py && m_v < m_py + SH) begin
        row = m_v - m_py;
        col = m_h - m_px;
        if (m_flip) col = SW - 1 - col;
        spr = mem[row][col];
      end
      e.h   = 11'(m_h);
      e.v   = 11'(m_v);
      e.vec = {hs, vs, act, {CW{spr & bus.rgb[RGB_R]}}, {CW{spr & bus.rgb[RGB_G]}},
               {CW{spr & bus.rgb[RGB_B]}}};
      sb.push_back(e);
      if (m_h == HT - 1) begin
        nv  = (m_v == VT - 1) ? 0 : m_v + 1;
        npy = (m_v == VT - 1) ? int'(bus.sprite_y) : m_py;
        m_ra = (nv < VA && nv >= npy && nv < npy + SH) ? nv - npy : 0;
        m_h = 0;
        if (m_v == VT - 1) begin
          m_v  = 0;
          m_px = int'(bus.sprite_x);
          m_py = int'(bus.sprite_y);
`ifdef VGA_SPRITE_HFLIP_EN
          m_flip = bus.hflip;
`endif
        end else begin
          m_v++;
        end
      end else begin
        m_h++;
      end
    end
    m_div = (m_div == PD - 1) ? 0 : m_div + 1;

    @(posedge clk); #1;
    cyc++;
    check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
    check("readaddress", 32'(bus.readaddress), 32'(m_ra));
    if (pix) begin
      e   = sb.pop_front();
      obs = {bus.hsync, bus.vsync, bus.active, bus.red, bus.green, bus.blue};
      check("pixel", 32'(obs), 32'(e.vec));
      if (bus.frame_start) begin
        if (frame_valid) begin
          f_hs = acc_hs; f_vs = acc_vs; f_red = acc_red; f_gb = acc_gb;
          f_white = acc_white; f_lit = acc_lit; f_blank = acc_blank; f_lit_h = acc_lit_h;
        end
        if (fs_last_cyc >= 0) check("fs_period", 32'(cyc - fs_last_cyc), 32'(FRAME_CLK));
        fs_last_cyc = cyc;
        frames++;
        frame_valid = 1'b1;
        clear_acc();
      end
      if (!bus.hsync) acc_hs++;
      if (!bus.vsync) acc_vs++;
      if (bus.red != 0) acc_red++;
      if (bus.green != 0 || bus.blue != 0) acc_gb++;
      if (bus.red == '1 && bus.green == '1 && bus.blue == '1) acc_white++;
      if ((bus.red | bus.green | bus.blue) != 0) begin
        acc_lit++;
        acc_lit_h = int'(e.h);
        if (!bus.active) acc_blank++;
      end
    end
  endtask

  task automatic run_frames(input int n);
    int target, budget;
    target = frames + n;
    budget = (n + 1) * FRAME_CLK;
    while (frames < target && budget > 0) begin
      tick();
      budget--;
    end
    if (frames < target) check("frame_timeout", 32'(frames), 32'(target));
  endtask

  task automatic run_until(input int v, input int h);
    int budget;
    budget = 2 * FRAME_CLK;
    while (!(m_v == v && m_h == h && m_div == 0) && budget > 0) begin
      tick();
      budget--;
    end
    if (budget == 0) check("pos_timeout", 32'(m_v), 32'(v));
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, 32'({bus.hsync, bus.vsync, bus.active, bus.red, bus.green, bus.blue,
                    bus.frame_start, bus.readaddress}),
          32'({1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 3'd0}));
  endtask

  int exp_lit;

  initial begin
    cyc = 0; frames = 0;
    bus.sprite_x = '0; bus.sprite_y = '0; bus.rgb = '0;
`ifdef VGA_SPRITE_HFLIP_EN
    bus.hflip = 1'b0;
`endif
    set_mem('0);
    reset_model();
    f_hs = 0; f_vs = 0; f_red = 0; f_gb = 0; f_white = 0; f_lit = 0; f_blank = 0; f_lit_h = -1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_state");
    rst = 1'b0;

    // blank screen: sync pulse widths and frame period
    run_frames(3);
    check("hsync_low_ticks", 32'(f_hs), 32'(HS * VT));
    check("vsync_low_ticks", 32'(f_vs), 32'(VS * HT));
    check("blank_lit", 32'(f_lit), 32'(0));

    // single red column
    bus.sprite_x = 10'd12; bus.sprite_y = 10'd8; bus.rgb = 3'b001;
    set_mem(16'h0001);
    run_frames(2);
    check("red_count", 32'(f_red), 32'(SH));
    check("red_only", 32'(f_gb), 32'(0));
    check("red_column", 32'(f_lit_h), 32'(12));

    // mid-frame move takes effect on the next frame only
    run_until(12, 0);
    bus.sprite_x = 10'd3;
    run_frames(1);
    check("no_tear_column", 32'(f_lit_h), 32'(12));
    run_frames(1);
    check("moved_column", 32'(f_lit_h), 32'(3));

    // right-edge clip, white
    bus.sprite_x = 10'(HA - 8); bus.rgb = 3'b111;
    set_mem('1);
    run_frames(2);
    check("white_clip", 32'(f_white), 32'(8 * SH));
    check("white_blank", 32'(f_blank), 32'(0));
    check("white_last_col", 32'(f_lit_h), 32'(HA - 1));

    // sprite fully off-screen
    bus.sprite_x = 10'(HA + 2);
    run_frames(2);
    check("offscreen_x", 32'(f_lit), 32'(0));
    bus.sprite_x = 10'd4; bus.sprite_y = 10'(VA + 2);
    run_frames(2);
    check("offscreen_y", 32'(f_lit), 32'(0));

    // random bitmap, clipped on both axes
    bus.sprite_x = 10'(HA - 6); bus.sprite_y = 10'(VA - 4); bus.rgb = 3'b110;
    for (int r = 0; r < SH; r++) mem[r] = 16'($urandom);
    exp_lit = 0;
    for (int r = 0; r < SH; r++)
      for (int c = 0; c < SW; c++)
        if (VA - 4 + r < VA && HA - 6 + c < HA && mem[r][c]) exp_lit++;
    run_frames(2);
    check("clip_lit", 32'(f_lit), 32'(exp_lit));
    check("clip_red", 32'(f_red), 32'(0));

    // asynchronous reset mid-frame
    run_until(12, 20);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_hold");
    rst = 1'b0;
    tick();
    check("fs_after_reset", 32'(bus.frame_start), 32'(1));
    run_frames(2);
    check("hsync_after_reset", 32'(f_hs), 32'(HS * VT));

`ifdef VGA_SPRITE_HFLIP_EN
    bus.sprite_x = 10'd8; bus.sprite_y = 10'd5; bus.rgb = 3'b001; bus.hflip = 1'b1;
    set_mem(16'h0001);
    run_frames(2);
    check("hflip_column", 32'(f_lit_h), 32'(8 + SW - 1));
    check("hflip_count", 32'(f_red), 32'(SH));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
